image_parallel_processing_pixel_dma_master: RTL

//  Avalon-MM master that streams a block of 32-bit pixel words out of on-chip image memory,

---
 rtl/image_pp_dma_pkg.sv | 21 ++
 rtl/image_pp_pixel_op.sv | 25 ++
 rtl/image_parallel_processing_pixel_dma_master.sv | 120 ++++++++++++
 3 files changed

// File: rtl/image_pp_dma_pkg.sv
// Shared types and constants for the pixel DMA master and its pixel operator.
package image_pp_dma_pkg;

    typedef enum logic [1:0] {
        OP_COPY,
        OP_INVERT,
        OP_THRESH,
        OP_RSVD
    } op_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        FINISH
    } state_t;

    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/image_pp_pixel_op.sv
// Byte-wise pixel operation over four packed 8-bit pixels; purely combinational.
module image_pp_pixel_op
    import image_pp_dma_pkg::*;
(
    input  logic [31:0] word,
    input  op_t         op,
    input  logic [7:0]  thresh,
    output logic [31:0] result
);

    always_comb begin
        result = word;
        unique case (op)
            OP_INVERT: result = ~word;
            OP_THRESH: begin
                for (int i = 0; i < 4; i++) begin
                    result[i*8 +: 8] = (word[i*8 +: 8] >= thresh) ? 8'hFF : 8'h00;
                end
            end
            // Reserved encoding falls through to a plain copy.
            default: result = word;
        endcase
    end

endmodule

// File: rtl/image_parallel_processing_pixel_dma_master.sv
// Avalon-MM master: reads one word at a time, applies the pixel op, writes it back out.
module image_parallel_processing_pixel_dma_master
    import image_pp_dma_pkg::*;
#(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned LEN_W  = 17
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [1:0]        op,
    input  logic [7:0]        thresh,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [LEN_W-1:0]  words_done,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    output logic              m_write,
    output logic [3:0]        m_byteenable,
    output logic [31:0]       m_writedata,
    input  logic [31:0]       m_readdata,
    input  logic              m_waitrequest,
    input  logic              m_readdatavalid
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, dst_q;
    logic [LEN_W-1:0]  len_q, words_done_q;
    op_t               op_q;
    logic [7:0]        thresh_q;
    logic [31:0]       wbuf_q;
    logic              aborted_q;
    logic [31:0]       op_result;

    logic start_ok, rd_capture, wr_fire, last_word;

    assign start_ok   = (state_q == IDLE) && start;
    assign rd_capture = (state_q == RD_WAIT) && m_readdatavalid;
    assign wr_fire    = (state_q == WR_REQ) && !m_waitrequest;
    assign last_word  = (words_done_q + LEN_W'(1)) == len_q;

    image_pp_pixel_op u_pixel_op (
        .word   (m_readdata),
        .op     (op_q),
        .thresh (thresh_q),
        .result (op_result)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = (len == '0) ? FINISH : RD_REQ;
            RD_REQ:  if (!m_waitrequest) state_d = RD_WAIT;
            RD_WAIT: if (m_readdatavalid) state_d = WR_REQ;
            WR_REQ:  if (!m_waitrequest) state_d = (last_word || abort) ? FINISH : RD_REQ;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            op_q         <= OP_COPY;
            thresh_q     <= '0;
            wbuf_q       <= '0;
            words_done_q <= '0;
            aborted_q    <= 1'b0;
        end else begin
            if (start_ok) begin
                // Low address bits are dropped so every beat stays word-aligned.
                src_q        <= {src_addr[ADDR_W-1:2], 2'b00};
                dst_q        <= {dst_addr[ADDR_W-1:2], 2'b00};
                len_q        <= len;
                op_q         <= op_t'(op);
                thresh_q     <= thresh;
                words_done_q <= '0;
                aborted_q    <= 1'b0;
            end
            if (rd_capture) begin
                wbuf_q <= op_result;
            end
            if (wr_fire) begin
                words_done_q <= words_done_q + LEN_W'(1);
                src_q        <= src_q + ADDR_W'(WORD_BYTES);
                dst_q        <= dst_q + ADDR_W'(WORD_BYTES);
                aborted_q    <= abort && !last_word;
            end
        end
    end

    always_comb begin
        busy         = (state_q == RD_REQ) || (state_q == RD_WAIT) || (state_q == WR_REQ);
        done         = (state_q == FINISH);
        m_read       = (state_q == RD_REQ);
        m_write      = (state_q == WR_REQ);
        m_address    = m_read ? src_q : (m_write ? dst_q : '0);
        m_writedata  = m_write ? wbuf_q : '0;
        m_byteenable = (m_read || m_write) ? 4'hF : 4'h0;
    end

    assign aborted    = aborted_q;
    assign words_done = words_done_q;

endmodule
